typedef_array_fifo: RTL

- Parametrised multi-lane synchronous FIFO whose storage word is a packed 2-D array of a typedef'd 1-bit alias: LANES lanes × LANE_W bits.
- Generalises the fixed 6-bit alias vector to configurable lane width, lane count and depth.
- Adds valid/ready handshaking, occupancy count, synchronous flush and an optional lane-reversed read view.
- Serves as a typedef'd packed-array regression vehicle and as a reusable buffer for self-checking benches.

---
 rtl/typedef_array_pkg.sv | 16 +
 rtl/typedef_array_lane_rev.sv | 31 +++
 rtl/typedef_array_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/typedef_array_pkg.sv
// Shared types and defaults for the typedef'd packed-array FIFO.
package typedef_array_pkg;

    // Single-bit alias used as the element type of every storage word.
    typedef logic logic_alias;

    localparam int unsigned LANE_W_DEF = 6;
    localparam int unsigned LANES_DEF  = 4;
    localparam int unsigned DEPTH_DEF  = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/typedef_array_lane_rev.sv
// Combinational lane-order view: optionally swaps lane k with lane LANES-1-k.
module typedef_array_lane_rev
    import typedef_array_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
) (
    input  logic                    rev,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);

    typedef logic_alias [LANES-1:0][LANE_W-1:0] word_t;

    word_t din_w;
    word_t dout_w;

    assign din_w = din;
    assign dout  = dout_w;

    // Pass-through by default, mirrored lane order when rev is set.
    always_comb begin
        dout_w = din_w;
        if (rev) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                dout_w[k] = din_w[LANES-1-k];
            end
        end
    end

endmodule

// File: rtl/typedef_array_fifo.sv
// Multi-lane synchronous FIFO with valid/ready handshakes, occupancy count,
// synchronous flush and an optional lane-reversed read view.
module typedef_array_fifo
    import typedef_array_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*LANE_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*LANE_W-1:0]    out_data,
    input  logic                       reverse,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef logic_alias [LANES-1:0][LANE_W-1:0] word_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("typedef_array_fifo: DEPTH must be a power of two >= 2");
    end
    if (LANE_W < 1 || LANES < 1) begin : g_bad_shape
        $error("typedef_array_fifo: LANE_W and LANES must be >= 1");
    end

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push, pop, wr_en;
    word_t            head;

    // Handshake flags come from the registered count only, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_en    = push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    typedef_array_lane_rev #(
        .LANE_W(LANE_W),
        .LANES (LANES)
    ) u_lane_rev (
        .rev (reverse),
        .din (head),
        .dout(out_data)
    );

    // Occupancy bound and pointers pinned while reset is held.
    always_ff @(posedge clk) begin
        assert (count_q <= FULL_CNT);
        if (!rst_n) assert (wr_ptr_q == '0 && rd_ptr_q == '0);
    end

endmodule
